// File: rtl/apb_bridge_pkg.sv
// ============================================================================
// apb_bridge_pkg
// Shared types and helpers for the APB requester bridge:
//   state_t    - bridge FSM states (IDLE / SETUP / ACCESS)
//   sel_width  - number of upper address bits used to pick a completer
//   rsp_ctl_t  - response control flags (valid pulse + error)
// ============================================================================
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // At least one select bit, even with a single completer, so that the
    // upper half of the address map reports a decode error.
    function automatic int sel_width(input int num_slaves);
        return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
    endfunction

    typedef struct packed {
        logic valid;
        logic err;
    } rsp_ctl_t;

endpackage

// File: rtl/apb_bridge_if.sv
// ============================================================================
// apb_bridge_if
// Bundles the request/response port and the N-completer APB bus of the bridge.
//   slave  modport : seen by the bridge (takes requests, drives APB)
//   master modport : seen by the request source / completer environment
// Parameters NUM_SLAVES, ADDR_W, DATA_W must match the bridge instance.
// ============================================================================
interface apb_bridge_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32
);
    // request / response side
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    // APB side
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [DATA_W-1:0]            pwdata;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_addr_decode.sv
// ============================================================================
// apb_addr_decode
// Combinational completer decode from the top SEL_BITS address bits.
//   addr       in  ADDR_W      request address
//   sel_onehot out NUM_SLAVES  one-hot completer select (all zero on error)
//   range_err  out 1           index does not map to an existing completer
// ============================================================================
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 8,
    parameter int SEL_BITS   = sel_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel_onehot,
    output logic                  range_err
);

    logic [SEL_BITS-1:0] idx;

    assign idx = addr[ADDR_W-1 -: SEL_BITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel_onehot[gi] = (32'(idx) == gi);
        end
    endgenerate

    assign range_err = (32'(idx) >= 32'(NUM_SLAVES));

endmodule

// File: rtl/apb_bridge_n.sv
// ============================================================================
// apb_bridge_n
// APB requester bridge: takes single read/write requests on a valid/ready
// port, decodes the completer from the upper address bits, runs an
// IDLE/SETUP/ACCESS transfer (PREADY wait states, PSLVERR) and returns one
// single-cycle response per request. Decode errors respond one cycle after
// acceptance without touching the APB bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : apb_bridge_if.slave (request/response port + APB bus)
// Build option: define APB_TIMEOUT_EN to abort an ACCESS phase that has not
// seen PREADY after TIMEOUT_CYCLES cycles (response with error).
// ============================================================================
module apb_bridge_n
    import apb_bridge_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    apb_bridge_if.slave  bus
);

    state_t                state_reg, state_next;
    rsp_ctl_t              rsp_ctl_reg, rsp_ctl_next;
    logic [DATA_W-1:0]     rsp_rdata_reg, rsp_rdata_next;

    logic [ADDR_W-1:0]     addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic                  write_reg;
    logic [NUM_SLAVES-1:0] sel_reg;

    logic [NUM_SLAVES-1:0] dec_onehot;
    logic                  dec_err;
    logic                  accept;
    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [DATA_W-1:0]     prdata_sel;
    logic [DATA_W-1:0]     prdata_masked [NUM_SLAVES];
    logic                  tmo_abort;

    apb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W)
    ) u_decode (
        .addr       (bus.req_addr),
        .sel_onehot (dec_onehot),
        .range_err  (dec_err)
    );

    assign bus.req_ready = (state_reg == ST_IDLE) & ~rst;
    assign accept        = bus.req_valid & bus.req_ready;

    // Only the latched completer contributes; everyone else is masked off.
    assign pready_sel  = |(bus.pready  & sel_reg);
    assign pslverr_sel = |(bus.pslverr & sel_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdmux
            assign prdata_masked[gi] = bus.prdata[gi*DATA_W +: DATA_W] & {DATA_W{sel_reg[gi]}};
        end
    endgenerate

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            prdata_sel = prdata_sel | prdata_masked[i];
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_reg;

    // Counts completed ACCESS cycles; value k means this is ACCESS cycle k+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_SETUP) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_ACCESS) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign tmo_abort = (state_reg == ST_ACCESS) && !pready_sel &&
                       (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // ACCESS waits for PREADY indefinitely; TIMEOUT_CYCLES has no effect here.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
    end
    assign tmo_abort = 1'b0;
`endif

    // Request latch: only decodable requests are captured so the APB address
    // and data lines do not move on a decode error.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
            sel_reg   <= '0;
        end else if (accept && !dec_err) begin
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            write_reg <= bus.req_write;
            sel_reg   <= dec_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rsp_ctl_reg   <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rsp_ctl_reg   <= rsp_ctl_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        rsp_ctl_next.valid = 1'b0;
        rsp_ctl_next.err   = rsp_ctl_reg.err;
        rsp_rdata_next     = rsp_rdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_err) begin
                        rsp_ctl_next.valid = 1'b1;
                        rsp_ctl_next.err   = 1'b1;
                        rsp_rdata_next     = '0;
                    end else begin
                        state_next = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_sel) begin
                    state_next         = ST_IDLE;
                    rsp_ctl_next.valid = 1'b1;
                    rsp_ctl_next.err   = pslverr_sel;
                    rsp_rdata_next     = (!write_reg && !pslverr_sel) ? prdata_sel : '0;
                end else if (tmo_abort) begin
                    state_next         = ST_IDLE;
                    rsp_ctl_next.valid = 1'b1;
                    rsp_ctl_next.err   = 1'b1;
                    rsp_rdata_next     = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.psel      = (state_reg == ST_SETUP || state_reg == ST_ACCESS) ? sel_reg : '0;
    assign bus.penable   = (state_reg == ST_ACCESS);
    assign bus.pwrite    = write_reg;
    assign bus.paddr     = addr_reg;
    assign bus.pwdata    = wdata_reg;
    assign bus.rsp_valid = rsp_ctl_reg.valid;
    assign bus.rsp_err   = rsp_ctl_reg.err;
    assign bus.rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_bridge_n.sv
// ============================================================================
// tb_apb_bridge_n
// Directed bench for apb_bridge_n: a 4-completer and a 3-completer instance.
// Stimulus pushes expected responses into per-instance queues; monitors pop
// and compare on every rsp_valid. APB-side timing is checked inline.
// ============================================================================
module tb_apb_bridge_n;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    apb_bridge_if #(.NUM_SLAVES(4), .ADDR_W(8), .DATA_W(32)) bus4();
    apb_bridge_if #(.NUM_SLAVES(3), .ADDR_W(8), .DATA_W(32)) bus3();

    apb_bridge_n #(.NUM_SLAVES(4), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    apb_bridge_n #(.NUM_SLAVES(3), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp4_q[$];
    exp_t exp3_q[$];

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PRDATA4_BASE = {32'hA0A00003, 32'hA0A00002, 32'hA0A00001, 32'hA0A00000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic wr, input logic [7:0] a, input logic [31:0] d);
        bus4.req_valid = v;
        bus4.req_write = wr;
        bus4.req_addr  = a;
        bus4.req_wdata = d;
    endtask

    task automatic drive3(input logic v, input logic wr, input logic [7:0] a, input logic [31:0] d);
        bus3.req_valid = v;
        bus3.req_write = wr;
        bus3.req_addr  = a;
        bus3.req_wdata = d;
    endtask

    function automatic exp_t mk(input logic e, input logic [31:0] d);
        exp_t r;
        r.err   = e;
        r.rdata = d;
        return r;
    endfunction

    // ---------------- response monitors ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus4.rsp_valid === 1'b1) begin
                if (exp4_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut4_unexpected_rsp actual=rsp_valid required=no response");
                end else begin
                    e = exp4_q.pop_front();
                    $display("rsp dut4 err=%0d rdata=0x%08h (expected err=%0d rdata=0x%08h)",
                             bus4.rsp_err, bus4.rsp_rdata, e.err, e.rdata);
                    check("dut4_rsp_err",   64'(bus4.rsp_err),   64'(e.err));
                    check("dut4_rsp_rdata", 64'(bus4.rsp_rdata), 64'(e.rdata));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus3.rsp_valid === 1'b1) begin
                if (exp3_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut3_unexpected_rsp actual=rsp_valid required=no response");
                end else begin
                    e = exp3_q.pop_front();
                    $display("rsp dut3 err=%0d rdata=0x%08h (expected err=%0d rdata=0x%08h)",
                             bus3.rsp_err, bus3.rsp_rdata, e.err, e.rdata);
                    check("dut3_rsp_err",   64'(bus3.rsp_err),   64'(e.err));
                    check("dut3_rsp_rdata", 64'(bus3.rsp_rdata), 64'(e.rdata));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive4(1'b0, 1'b0, 8'h00, 32'h0);
        drive3(1'b0, 1'b0, 8'h00, 32'h0);
        bus4.pready  = 4'b1111;
        bus4.pslverr = 4'b0000;
        bus4.prdata  = PRDATA4_BASE;
        bus3.pready  = 3'b111;
        bus3.pslverr = 3'b000;
        bus3.prdata  = {32'hB0B00002, 32'hB0B00001, 32'hB0B00000};

        tick();
        tick();
        check("rst_psel",      64'(bus4.psel),      64'h0);
        check("rst_penable",   64'(bus4.penable),   64'h0);
        check("rst_pwrite",    64'(bus4.pwrite),    64'h0);
        check("rst_paddr",     64'(bus4.paddr),     64'h0);
        check("rst_pwdata",    64'(bus4.pwdata),    64'h0);
        check("rst_rsp_valid", 64'(bus4.rsp_valid), 64'h0);
        check("rst_rsp_err",   64'(bus4.rsp_err),   64'h0);
        check("rst_rsp_rdata", 64'(bus4.rsp_rdata), 64'h0);
        check("rst_req_ready", 64'(bus4.req_ready), 64'h0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 64'(bus4.req_ready), 64'h1);

        // 1: write 0x40 <= 0xDEADBEEF, zero wait states
        drive4(1'b1, 1'b1, 8'h40, 32'hDEADBEEF);
        exp4_q.push_back(mk(1'b0, 32'h0));
        tick();
        drive4(1'b0, 1'b0, 8'h00, 32'h0);
        check("t1_c1_psel",    64'(bus4.psel),    64'h2);
        check("t1_c1_penable", 64'(bus4.penable), 64'h0);
        check("t1_c1_paddr",   64'(bus4.paddr),   64'h40);
        check("t1_c1_pwrite",  64'(bus4.pwrite),  64'h1);
        tick();
        check("t1_c2_psel",      64'(bus4.psel),      64'h2);
        check("t1_c2_penable",   64'(bus4.penable),   64'h1);
        check("t1_c2_pwdata",    64'(bus4.pwdata),    64'hDEADBEEF);
        check("t1_c2_rsp_valid", 64'(bus4.rsp_valid), 64'h0);
        tick();
        check("t1_c3_rsp_valid", 64'(bus4.rsp_valid), 64'h1);
        check("t1_c3_req_ready", 64'(bus4.req_ready), 64'h1);
        check("t1_c3_psel",      64'(bus4.psel),      64'h0);
        check("t1_c3_penable",   64'(bus4.penable),   64'h0);

        // 2: read 0xC4, completer 3 holds pready low for two ACCESS cycles
        bus4.pready = 4'b0111;
        bus4.prdata = {32'h12345678, PRDATA4_BASE[95:0]};
        drive4(1'b1, 1'b0, 8'hC4, 32'hFFFFFFFF);
        exp4_q.push_back(mk(1'b0, 32'h12345678));
        tick();
        drive4(1'b0, 1'b0, 8'h00, 32'h0);
        check("t2_setup_psel", 64'(bus4.psel), 64'h8);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) bus4.pready = 4'b1111;
            check("t2_access_penable", 64'(bus4.penable), 64'h1);
            check("t2_access_paddr",   64'(bus4.paddr),   64'hC4);
            check("t2_access_psel",    64'(bus4.psel),    64'h8);
        end
        tick();
        check("t2_rsp_valid", 64'(bus4.rsp_valid), 64'h1);
        tick();
        check("t2_hold_rsp_valid", 64'(bus4.rsp_valid), 64'h0);
        check("t2_hold_rsp_rdata", 64'(bus4.rsp_rdata), 64'h12345678);
        bus4.prdata = PRDATA4_BASE;

        // 3: read 0x08, completer 0 answers with PSLVERR
        bus4.pslverr = 4'b0001;
        drive4(1'b1, 1'b0, 8'h08, 32'h0);
        exp4_q.push_back(mk(1'b1, 32'h0));
        tick();
        drive4(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        tick();
        check("t3_rsp_valid", 64'(bus4.rsp_valid), 64'h1);
        bus4.pslverr = 4'b0000;

        // back-to-back: read 0x80, second request (0x44) accepted on the response cycle
        drive4(1'b1, 1'b0, 8'h80, 32'h0);
        exp4_q.push_back(mk(1'b0, 32'hA0A00002));
        tick();
        drive4(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        tick();
        check("b2b_rsp_valid", 64'(bus4.rsp_valid), 64'h1);
        drive4(1'b1, 1'b0, 8'h44, 32'h0);
        #1;
        check("b2b_req_ready", 64'(bus4.req_ready), 64'h1);
        exp4_q.push_back(mk(1'b0, 32'hA0A00001));
        tick();
        drive4(1'b0, 1'b0, 8'h00, 32'h0);
        check("b2b_setup_psel", 64'(bus4.psel), 64'h2);
        tick();
        tick();

        // 4: three completers, 0xC0 is out of range
        drive3(1'b1, 1'b0, 8'hC0, 32'h0);
        exp3_q.push_back(mk(1'b1, 32'h0));
        tick();
        drive3(1'b0, 1'b0, 8'h00, 32'h0);
        check("t4_c1_rsp_valid", 64'(bus3.rsp_valid), 64'h1);
        check("t4_c1_rsp_err",   64'(bus3.rsp_err),   64'h1);
        check("t4_c1_psel",      64'(bus3.psel),      64'h0);
        check("t4_c1_req_ready", 64'(bus3.req_ready), 64'h1);
        tick();
        check("t4_c2_psel",      64'(bus3.psel),      64'h0);
        check("t4_c2_penable",   64'(bus3.penable),   64'h0);
        // 0x80 maps to the last existing completer
        drive3(1'b1, 1'b1, 8'h80, 32'h000055AA);
        exp3_q.push_back(mk(1'b0, 32'h0));
        tick();
        drive3(1'b0, 1'b0, 8'h00, 32'h0);
        check("t4w_setup_psel", 64'(bus3.psel), 64'h4);
        tick();
        check("t4w_pwdata", 64'(bus3.pwdata), 64'h55AA);
        tick();
        check("t4w_rsp_valid", 64'(bus3.rsp_valid), 64'h1);
        tick();

        // 5: reset while in ACCESS drops the transfer
        bus4.pready = 4'b1101;
        drive4(1'b1, 1'b0, 8'h40, 32'h0);
        tick();
        drive4(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        check("t5_access_penable", 64'(bus4.penable), 64'h1);
        rst = 1'b1;
        tick();
        check("t5_rst_psel",      64'(bus4.psel),      64'h0);
        check("t5_rst_penable",   64'(bus4.penable),   64'h0);
        check("t5_rst_rsp_valid", 64'(bus4.rsp_valid), 64'h0);
        rst = 1'b0;
        bus4.pready = 4'b1111;
        #1;
        check("t5_req_ready", 64'(bus4.req_ready), 64'h1);
        tick();
        check("t5_no_rsp", 64'(bus4.rsp_valid), 64'h0);

        // 6: completer 2 never answers
        bus4.pready = 4'b1011;
        drive4(1'b1, 1'b0, 8'h80, 32'h0);
`ifdef APB_TIMEOUT_EN
        exp4_q.push_back(mk(1'b1, 32'h0));
`endif
        tick();
        drive4(1'b0, 1'b0, 8'h00, 32'h0);
        for (int k = 2; k <= 17; k++) tick();
        check("t6_c17_penable",   64'(bus4.penable),   64'h1);
        check("t6_c17_rsp_valid", 64'(bus4.rsp_valid), 64'h0);
        tick();
`ifdef APB_TIMEOUT_EN
        check("t6_tmo_rsp_valid", 64'(bus4.rsp_valid), 64'h1);
        check("t6_tmo_psel",      64'(bus4.psel),      64'h0);
        check("t6_tmo_penable",   64'(bus4.penable),   64'h0);
`else
        for (int k = 0; k < 100; k++) tick();
        check("t6_wait_penable", 64'(bus4.penable), 64'h1);
        check("t6_wait_psel",    64'(bus4.psel),    64'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        bus4.pready = 4'b1111;
        tick();
        tick();
        tick();

        check("end_exp4_empty", 64'(exp4_q.size()), 64'h0);
        check("end_exp3_empty", 64'(exp3_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
